// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg : shared widths and queue entry type for the writeback queue
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo : 2-write / 2-read circular buffer of writeback entries
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       wrA_i,
  input  wb_entry_t                  entA_i,
  input  logic                       wrB_i,
  input  wb_entry_t                  entB_i,
  input  logic [1:0]                 rdCnt_i,
  output wb_entry_t                  head_o,
  output wb_entry_t                  head1_o,
  output wb_entry_t                  entries_o [DEPTH],
  output logic [$clog2(DEPTH)-1:0]   headPtr_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] tailP1;
  logic [PTR_W-1:0] headP1;
  logic [CNT_W-1:0] count_q, count_d;

  assign tailP1 = tail_q + 1'b1;
  assign headP1 = head_q + 1'b1;

  always_comb begin
    tail_d  = tail_q + PTR_W'(wrA_i) + PTR_W'(wrB_i);
    head_d  = head_q + PTR_W'(rdCnt_i);
    count_d = count_q + CNT_W'(wrA_i) + CNT_W'(wrB_i) - CNT_W'(rdCnt_i);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only slots inside [head, head+count) are ever observed.
  always_ff @(posedge clock_i) begin
    if (wrA_i) mem_q[tail_q] <= entA_i;
    if (wrB_i) mem_q[wrA_i ? tailP1 : tail_q] <= entB_i;
  end

  assign head_o    = mem_q[head_q];
  assign head1_o   = mem_q[headP1];
  assign entries_o = mem_q;
  assign headPtr_o = head_q;
  assign count_o   = count_q;

endmodule

`default_nettype wire

// File: rtl/writeback_queue.sv
// ---------------------------------------------------------------------------
// writeback_queue : in-order result buffer draining two writes per cycle to
//                   the register file, with combinational pending-write forwarding
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module writeback_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = wb_pkg::ADDR_W,
  parameter int DATA_W = wb_pkg::DATA_W
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              resAValid_i,
  input  logic [ADDR_W-1:0] resAAddr_i,
  input  logic [DATA_W-1:0] resAData_i,
  input  logic              resBValid_i,
  input  logic [ADDR_W-1:0] resBAddr_i,
  input  logic [DATA_W-1:0] resBData_i,
  output logic              resReady_o,
  input  logic              holdWb_i,
  output logic              writeEnablePortA_o,
  output logic [ADDR_W-1:0] writeAPortAddr_o,
  output logic [DATA_W-1:0] writeAPortData_o,
  output logic              writeEnablePortB_o,
  output logic [ADDR_W-1:0] writeBPortAddr_o,
  output logic [DATA_W-1:0] writeBPortData_o,
  input  logic [ADDR_W-1:0] qryAddr_i,
  output logic              qryHit_o,
  output logic [DATA_W-1:0] qryData_o,
  output logic              wbIdle_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_pkg::wb_entry_t entA, entB, head, head1;
  wb_pkg::wb_entry_t entries [DEPTH];
  logic [PTR_W-1:0]  headPtr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  countNext;
  logic [CNT_W-1:0]  freeNext;
  logic [1:0]        deqCnt;
  logic              acceptA, acceptB, issueA, issueB;

  logic              weA_q, weA_d, weB_q, weB_d;
  logic [ADDR_W-1:0] addrA_q, addrA_d, addrB_q, addrB_d;
  logic [DATA_W-1:0] dataA_q, dataA_d, dataB_q, dataB_d;
  logic              ready_q, ready_d, idle_q, idle_d;

  assign acceptA = resAValid_i & ready_q;
  assign acceptB = resBValid_i & ready_q;
  assign entA    = '{addr: resAAddr_i, data: resAData_i};
  assign entB    = '{addr: resBAddr_i, data: resBData_i};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .wrA_i     (acceptA),
    .entA_i    (entA),
    .wrB_i     (acceptB),
    .entB_i    (entB),
    .rdCnt_i   (deqCnt),
    .head_o    (head),
    .head1_o   (head1),
    .entries_o (entries),
    .headPtr_o (headPtr),
    .count_o   (count)
  );

  // A same-address pair drains one per cycle so the younger write lands last.
  always_comb begin
    issueA = 1'b0;
    issueB = 1'b0;
    if (!holdWb_i) begin
      issueA = (count != '0);
      issueB = (count >= CNT_W'(2)) && (head1.addr != head.addr);
    end
    deqCnt    = {1'b0, issueA} + {1'b0, issueB};
    countNext = count + CNT_W'(acceptA) + CNT_W'(acceptB) - CNT_W'(deqCnt);
    freeNext  = CNT_W'(DEPTH) - countNext;
  end

  always_comb begin
    weA_d   = issueA;
    addrA_d = '0;
    dataA_d = '0;
    weB_d   = issueB;
    addrB_d = '0;
    dataB_d = '0;
    if (issueA) begin
      addrA_d = head.addr;
      dataA_d = head.data;
    end
    if (issueB) begin
      addrB_d = head1.addr;
      dataB_d = head1.data;
    end
    ready_d = (freeNext >= CNT_W'(2));
    idle_d  = (countNext == '0) && !issueA && !issueB;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      weA_q   <= 1'b0;
      addrA_q <= '0;
      dataA_q <= '0;
      weB_q   <= 1'b0;
      addrB_q <= '0;
      dataB_q <= '0;
      ready_q <= 1'b1;
      idle_q  <= 1'b1;
    end else begin
      weA_q   <= weA_d;
      addrA_q <= addrA_d;
      dataA_q <= dataA_d;
      weB_q   <= weB_d;
      addrB_q <= addrB_d;
      dataB_q <= dataB_d;
      ready_q <= ready_d;
      idle_q  <= idle_d;
    end
  end

  // Oldest first so each later (younger) match overrides: port A, port B, head..tail.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    qryHit_o  = 1'b0;
    qryData_o = '0;
    if (weA_q && (addrA_q == qryAddr_i)) begin
      qryHit_o  = 1'b1;
      qryData_o = dataA_q;
    end
    if (weB_q && (addrB_q == qryAddr_i)) begin
      qryHit_o  = 1'b1;
      qryData_o = dataB_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[idx].addr == qryAddr_i)) begin
        qryHit_o  = 1'b1;
        qryData_o = entries[idx].data;
      end
    end
  end

  assign resReady_o         = ready_q;
  assign wbIdle_o           = idle_q;
  assign writeEnablePortA_o = weA_q;
  assign writeAPortAddr_o   = addrA_q;
  assign writeAPortData_o   = dataA_q;
  assign writeEnablePortB_o = weB_q;
  assign writeBPortAddr_o   = addrB_q;
  assign writeBPortData_o   = dataB_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_queue.sv
// ---------------------------------------------------------------------------
// tb_writeback_queue : directed self-checking bench for writeback_queue
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_writeback_queue;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic              clock_i = 1'b0;
  logic              reset_i = 1'b1;
  logic              resAValid_i = 1'b0;
  logic [ADDR_W-1:0] resAAddr_i = '0;
  logic [DATA_W-1:0] resAData_i = '0;
  logic              resBValid_i = 1'b0;
  logic [ADDR_W-1:0] resBAddr_i = '0;
  logic [DATA_W-1:0] resBData_i = '0;
  logic              holdWb_i = 1'b0;
  logic [ADDR_W-1:0] qryAddr_i = '0;
  logic              resReady_o;
  logic              writeEnablePortA_o, writeEnablePortB_o;
  logic [ADDR_W-1:0] writeAPortAddr_o, writeBPortAddr_o;
  logic [DATA_W-1:0] writeAPortData_o, writeBPortData_o;
  logic              qryHit_o;
  logic [DATA_W-1:0] qryData_o;
  logic              wbIdle_o;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W+DATA_W-1:0] wr_log [$];
  logic [ADDR_W+DATA_W-1:0] exp_log [$];

  writeback_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clock_i            (clock_i),
    .reset_i            (reset_i),
    .resAValid_i        (resAValid_i),
    .resAAddr_i         (resAAddr_i),
    .resAData_i         (resAData_i),
    .resBValid_i        (resBValid_i),
    .resBAddr_i         (resBAddr_i),
    .resBData_i         (resBData_i),
    .resReady_o         (resReady_o),
    .holdWb_i           (holdWb_i),
    .writeEnablePortA_o (writeEnablePortA_o),
    .writeAPortAddr_o   (writeAPortAddr_o),
    .writeAPortData_o   (writeAPortData_o),
    .writeEnablePortB_o (writeEnablePortB_o),
    .writeBPortAddr_o   (writeBPortAddr_o),
    .writeBPortData_o   (writeBPortData_o),
    .qryAddr_i          (qryAddr_i),
    .qryHit_o           (qryHit_o),
    .qryData_o          (qryData_o),
    .wbIdle_o           (wbIdle_o)
  );

  always #5 clock_i = ~clock_i;

  // Register-file model: commits in port order, A before B within a cycle.
  always @(negedge clock_i) begin
    if (writeEnablePortA_o) wr_log.push_back({writeAPortAddr_o, writeAPortData_o});
    if (writeEnablePortB_o) wr_log.push_back({writeBPortAddr_o, writeBPortData_o});
  end

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic clear_valids();
    resAValid_i = 1'b0;
    resBValid_i = 1'b0;
  endtask

  task automatic drive_pair(input logic va, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] da,
                            input logic vb, input logic [ADDR_W-1:0] ab, input logic [DATA_W-1:0] db);
    resAValid_i = va; resAAddr_i = aa; resAData_i = da;
    resBValid_i = vb; resBAddr_i = ab; resBData_i = db;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 100 && !wbIdle_o; c++) step();
    checks++;
    if (wbIdle_o !== 1'b1) begin
      failures++;
      $display("FAIL %s idle_timeout: wbIdle_o=%b required 1", name, wbIdle_o);
    end
  endtask

  task automatic compare_logs(input string name);
    checks++;
    if (wr_log.size() != exp_log.size()) begin
      failures++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_log.size(), exp_log.size());
    end
    for (int i = 0; i < wr_log.size() && i < exp_log.size(); i++) begin
      checks++;
      if (wr_log[i] !== exp_log[i]) begin
        failures++;
        $display("FAIL %s write[%0d]: got addr=%0d data=%h required addr=%0d data=%h", name, i,
                 wr_log[i][DATA_W+:ADDR_W], wr_log[i][DATA_W-1:0],
                 exp_log[i][DATA_W+:ADDR_W], exp_log[i][DATA_W-1:0]);
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    clear_valids();
    holdWb_i  = 1'b0;
    qryAddr_i = 5'd3;
    step();
    step();
    reset_i = 1'b0;
    step();
    checks++; if (resReady_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b required 1", resReady_o); end
    checks++; if (wbIdle_o !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b required 1", wbIdle_o); end
    checks++; if (writeEnablePortA_o !== 1'b0) begin failures++; $display("FAIL reset_weA: got %b required 0", writeEnablePortA_o); end
    checks++; if (writeEnablePortB_o !== 1'b0) begin failures++; $display("FAIL reset_weB: got %b required 0", writeEnablePortB_o); end
    checks++; if (qryHit_o !== 1'b0) begin failures++; $display("FAIL reset_qryHit: got %b required 0", qryHit_o); end
    checks++; if (qryData_o !== 16'h0) begin failures++; $display("FAIL reset_qryData: got %h required 0000", qryData_o); end
  endtask

  task automatic test_dual_issue();
    drive_pair(1'b1, 5'd3, 16'h1111, 1'b1, 5'd4, 16'h2222);
    step();
    clear_valids();
    qryAddr_i = 5'd3; #1;
    checks++; if (qryHit_o !== 1'b1 || qryData_o !== 16'h1111) begin failures++; $display("FAIL pair_qry_queued: got hit=%b data=%h required hit=1 data=1111", qryHit_o, qryData_o); end
    checks++; if (wbIdle_o !== 1'b0) begin failures++; $display("FAIL pair_idle_busy: got %b required 0", wbIdle_o); end
    step();
    checks++; if (writeEnablePortA_o !== 1'b1 || writeAPortAddr_o !== 5'd3 || writeAPortData_o !== 16'h1111) begin
      failures++; $display("FAIL pair_portA: got we=%b addr=%0d data=%h required we=1 addr=3 data=1111", writeEnablePortA_o, writeAPortAddr_o, writeAPortData_o); end
    checks++; if (writeEnablePortB_o !== 1'b1 || writeBPortAddr_o !== 5'd4 || writeBPortData_o !== 16'h2222) begin
      failures++; $display("FAIL pair_portB: got we=%b addr=%0d data=%h required we=1 addr=4 data=2222", writeEnablePortB_o, writeBPortAddr_o, writeBPortData_o); end
    qryAddr_i = 5'd4; #1;
    checks++; if (qryHit_o !== 1'b1 || qryData_o !== 16'h2222) begin failures++; $display("FAIL pair_qry_inflight: got hit=%b data=%h required hit=1 data=2222", qryHit_o, qryData_o); end
    step();
    checks++; if (wbIdle_o !== 1'b1 || writeEnablePortA_o !== 1'b0 || writeEnablePortB_o !== 1'b0) begin
      failures++; $display("FAIL pair_idle_after: got idle=%b weA=%b weB=%b required idle=1 weA=0 weB=0", wbIdle_o, writeEnablePortA_o, writeEnablePortB_o); end
  endtask

  task automatic test_collision();
    drive_pair(1'b1, 5'd5, 16'hAAAA, 1'b1, 5'd5, 16'hBBBB);
    step();
    clear_valids();
    qryAddr_i = 5'd5; #1;
    checks++; if (qryHit_o !== 1'b1 || qryData_o !== 16'hBBBB) begin failures++; $display("FAIL coll_qry_queued: got hit=%b data=%h required hit=1 data=bbbb", qryHit_o, qryData_o); end
    step();
    checks++; if (writeEnablePortA_o !== 1'b1 || writeAPortAddr_o !== 5'd5 || writeAPortData_o !== 16'hAAAA || writeEnablePortB_o !== 1'b0) begin
      failures++; $display("FAIL coll_cycle1: got weA=%b addr=%0d data=%h weB=%b required weA=1 addr=5 data=aaaa weB=0", writeEnablePortA_o, writeAPortAddr_o, writeAPortData_o, writeEnablePortB_o); end
    checks++; if (qryHit_o !== 1'b1 || qryData_o !== 16'hBBBB) begin failures++; $display("FAIL coll_qry_youngest: got hit=%b data=%h required hit=1 data=bbbb", qryHit_o, qryData_o); end
    step();
    checks++; if (writeEnablePortA_o !== 1'b1 || writeAPortAddr_o !== 5'd5 || writeAPortData_o !== 16'hBBBB || writeEnablePortB_o !== 1'b0) begin
      failures++; $display("FAIL coll_cycle2: got weA=%b addr=%0d data=%h weB=%b required weA=1 addr=5 data=bbbb weB=0", writeEnablePortA_o, writeAPortAddr_o, writeAPortData_o, writeEnablePortB_o); end
    checks++; if (qryHit_o !== 1'b1 || qryData_o !== 16'hBBBB) begin failures++; $display("FAIL coll_qry_port: got hit=%b data=%h required hit=1 data=bbbb", qryHit_o, qryData_o); end
    step();
    checks++; if (qryHit_o !== 1'b0 || wbIdle_o !== 1'b1) begin failures++; $display("FAIL coll_drained: got hit=%b idle=%b required hit=0 idle=1", qryHit_o, wbIdle_o); end
  endtask

  task automatic test_hold_backpressure();
    wr_log.delete();
    exp_log.delete();
    holdWb_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_pair(1'b1, 5'(8 + 2 * k), 16'(16'h3000 + 2 * k), 1'b1, 5'(9 + 2 * k), 16'(16'h3001 + 2 * k));
      exp_log.push_back({5'(8 + 2 * k), 16'(16'h3000 + 2 * k)});
      exp_log.push_back({5'(9 + 2 * k), 16'(16'h3001 + 2 * k)});
      step();
      checks++;
      if (resReady_o !== ((8 - 2 * (k + 1)) >= 2) || writeEnablePortA_o !== 1'b0) begin
        failures++; $display("FAIL hold_fill[%0d]: got ready=%b weA=%b required ready=%b weA=0", k, resReady_o, writeEnablePortA_o, ((8 - 2 * (k + 1)) >= 2));
      end
    end
    drive_pair(1'b1, 5'd31, 16'hDEAD, 1'b1, 5'd30, 16'hBEEF);
    step();
    clear_valids();
    checks++; if (resReady_o !== 1'b0 || wbIdle_o !== 1'b0) begin failures++; $display("FAIL hold_full: got ready=%b idle=%b required ready=0 idle=0", resReady_o, wbIdle_o); end
    holdWb_i = 1'b0;
    step();
    checks++; if (writeEnablePortA_o !== 1'b1 || writeEnablePortB_o !== 1'b1 || writeAPortAddr_o !== 5'd8 || writeBPortAddr_o !== 5'd9) begin
      failures++; $display("FAIL hold_release: got weA=%b weB=%b addrA=%0d addrB=%0d required 1 1 8 9", writeEnablePortA_o, writeEnablePortB_o, writeAPortAddr_o, writeBPortAddr_o); end
    checks++; if (resReady_o !== 1'b1) begin failures++; $display("FAIL hold_ready_back: got %b required 1", resReady_o); end
    wait_idle("hold");
    compare_logs("hold");
  endtask

  task automatic test_wrap();
    int n;
    wr_log.delete();
    exp_log.delete();
    n = 0;
    for (int c = 0; c < 400 && n < 20; c++) begin
      holdWb_i = ($urandom_range(0, 3) == 0);
      clear_valids();
      if (resReady_o) begin
        if ($urandom_range(0, 3) != 0) begin
          drive_pair(1'b1, 5'(n % 7), 16'(16'h5000 + n), resBValid_i, resBAddr_i, resBData_i);
          exp_log.push_back({5'(n % 7), 16'(16'h5000 + n)});
          n++;
        end
        if (n < 20 && $urandom_range(0, 1) != 0) begin
          drive_pair(resAValid_i, resAAddr_i, resAData_i, 1'b1, 5'(n % 7), 16'(16'h5000 + n));
          exp_log.push_back({5'(n % 7), 16'(16'h5000 + n)});
          n++;
        end
      end
      step();
    end
    clear_valids();
    holdWb_i = 1'b0;
    checks++; if (n != 20) begin failures++; $display("FAIL wrap_accept: got %0d results accepted required 20", n); end
    wait_idle("wrap");
    compare_logs("wrap");
  endtask

  task automatic test_reset_pending();
    wr_log.delete();
    holdWb_i = 1'b1;
    drive_pair(1'b1, 5'd20, 16'h7000, 1'b1, 5'd21, 16'h7001); step();
    drive_pair(1'b1, 5'd22, 16'h7002, 1'b1, 5'd23, 16'h7003); step();
    drive_pair(1'b1, 5'd24, 16'h7004, 1'b0, 5'd0, 16'h0);     step();
    clear_valids();
    qryAddr_i = 5'd24; #1;
    checks++; if (qryHit_o !== 1'b1 || qryData_o !== 16'h7004) begin failures++; $display("FAIL rstp_qry_before: got hit=%b data=%h required hit=1 data=7004", qryHit_o, qryData_o); end
    reset_i  = 1'b1;
    holdWb_i = 1'b0;
    step();
    checks++; if (writeEnablePortA_o !== 1'b0 || writeEnablePortB_o !== 1'b0 || wbIdle_o !== 1'b1 || resReady_o !== 1'b1) begin
      failures++; $display("FAIL rstp_state: got weA=%b weB=%b idle=%b ready=%b required 0 0 1 1", writeEnablePortA_o, writeEnablePortB_o, wbIdle_o, resReady_o); end
    checks++; if (qryHit_o !== 1'b0) begin failures++; $display("FAIL rstp_qry_after: got hit=%b required 0", qryHit_o); end
    reset_i = 1'b0;
    for (int c = 0; c < 10; c++) step();
    checks++; if (wr_log.size() != 0) begin failures++; $display("FAIL rstp_stale: got %0d writes required 0", wr_log.size()); end
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_collision();
    test_hold_backpressure();
    test_wrap();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
